// File: rtl/sram_bit_arb.sv
// Two-requester arbiter in front of a single-port bit-masked SRAM, with a full-array clear sequencer.
// Transfers register onto the SRAM pins one cycle after grant; read data and rvalid follow two edges after the grant edge.
module sram_bit_arb #(
  parameter int DW = 140,
  parameter int DD = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          clr_start,
  output logic          init_done,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_mask,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_mask,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          sram_n_cs,
  output logic          sram_n_we,
  output logic          sram_n_oe,
  output logic [DW-1:0] sram_mask,
  output logic [DW-1:0] sram_din,
  output logic [AW-1:0] sram_ad,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_AD = AW'(DD - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last_b;
  logic          run, xfer;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_mask, sel_wdata;

  logic          n_cs_nxt, n_we_nxt, n_oe_nxt;
  logic [DW-1:0] mask_nxt, din_nxt;
  logic [AW-1:0] ad_nxt;

  // Read pipeline: stage1 = command on pins, stage2 = SRAM output valid, stage3 = rdata valid
  logic rv1, rv2, rv3;
  logic who1, who2, who3;

  assign run       = (state == RUN);
  assign init_done = run;

  // On a tie, last_b set means B won last, so A wins now
  assign a_gnt = run & a_req & (~b_req | last_b);
  assign b_gnt = run & b_req & (~a_req | ~last_b);
  assign xfer  = a_gnt | b_gnt;

  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_mask  = b_gnt ? b_mask  : a_mask;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        if (cnt == LAST_AD) state_nxt = RUN;
        else                cnt_nxt   = cnt + AW'(1);
      end
      RUN: begin
        if (clr_start) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    n_cs_nxt = 1'b1;
    n_we_nxt = 1'b1;
    n_oe_nxt = 1'b1;
    mask_nxt = '1;
    ad_nxt   = sram_ad;
    din_nxt  = sram_din;
    if (state == INIT) begin
      n_cs_nxt = 1'b0;
      n_we_nxt = 1'b0;
      mask_nxt = '0;
      ad_nxt   = cnt;
      din_nxt  = '0;
    end else if (xfer) begin
      n_cs_nxt = 1'b0;
      n_we_nxt = ~sel_we;
      n_oe_nxt = sel_we;
      mask_nxt = sel_mask;
      ad_nxt   = sel_addr;
      din_nxt  = sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= INIT;
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (xfer) last_b <= b_gnt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sram_n_cs <= 1'b1;
      sram_n_we <= 1'b1;
      sram_n_oe <= 1'b1;
      sram_mask <= '1;
      sram_ad   <= '0;
      sram_din  <= '0;
    end else begin
      sram_n_cs <= n_cs_nxt;
      sram_n_we <= n_we_nxt;
      sram_n_oe <= n_oe_nxt;
      sram_mask <= mask_nxt;
      sram_ad   <= ad_nxt;
      sram_din  <= din_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rv1   <= 1'b0;
      rv2   <= 1'b0;
      rv3   <= 1'b0;
      who1  <= 1'b0;
      who2  <= 1'b0;
      who3  <= 1'b0;
      rdata <= '0;
    end else begin
      rv1  <= xfer & ~sel_we;
      who1 <= b_gnt;
      rv2  <= rv1;
      who2 <= who1;
      rv3  <= rv2;
      who3 <= who2;
      if (rv2) rdata <= sram_dout;
    end
  end

  assign a_rvalid = rv3 & ~who3;
  assign b_rvalid = rv3 & who3;

endmodule

// File: tb/tb_sram_bit_arb.sv
// Directed bench for sram_bit_arb with a behavioural bit-masked synchronous SRAM.
module tb_sram_bit_arb;

  localparam int DW = 8;
  localparam int DD = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          n_reset, clr_start, init_done;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] a_addr, b_addr, sram_ad;
  logic [DW-1:0] a_mask, a_wdata, b_mask, b_wdata;
  logic [DW-1:0] rdata, sram_mask, sram_din, sram_dout;
  logic          sram_n_cs, sram_n_we, sram_n_oe;

  logic [DW-1:0] mem [2**AW];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_bit_arb #(.DW(DW), .DD(DD), .AW(AW)) dut (
    .clk(clk), .n_reset(n_reset), .clr_start(clr_start), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_mask(a_mask), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_mask(b_mask), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .sram_n_cs(sram_n_cs), .sram_n_we(sram_n_we), .sram_n_oe(sram_n_oe),
    .sram_mask(sram_mask), .sram_din(sram_din), .sram_ad(sram_ad), .sram_dout(sram_dout)
  );

  // Synchronous SRAM: masked write merge, read returns the pre-write word
  always @(posedge clk) begin
    if (!sram_n_cs) begin
      if (!sram_n_we) mem[sram_ad] <= (sram_din & ~sram_mask) | (mem[sram_ad] & sram_mask);
      if (!sram_n_oe) sram_dout <= mem[sram_ad];
    end
  end

  typedef struct {
    logic          a_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_mask, a_wdata;
    logic          b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_mask, b_wdata;
    logic          e_ga, e_gb, e_rva, e_rvb, e_ncs;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input int ar, aw, aa, am, ad, br, bw, ba, bm, bd,
                              input int ga, gb, rva, rvb, ncs, rd);
    vec_t v;
    v.a_req = 1'(ar);  v.a_we = 1'(aw);  v.a_addr = AW'(aa);
    v.a_mask = DW'(am); v.a_wdata = DW'(ad);
    v.b_req = 1'(br);  v.b_we = 1'(bw);  v.b_addr = AW'(ba);
    v.b_mask = DW'(bm); v.b_wdata = DW'(bd);
    v.e_ga = 1'(ga); v.e_gb = 1'(gb); v.e_rva = 1'(rva); v.e_rvb = 1'(rvb);
    v.e_ncs = 1'(ncs); v.e_rd = DW'(rd);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic next_row();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0;
  endtask

  int  wr, idle_n, a_rv_j, b_rv_j;
  bit  gnt_bad, rv_seen;
  logic [DW-1:0] a_rd, b_rd;

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'hAA;
    sram_dout = '0;
    n_reset = 1'b1; clr_start = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_mask = '0; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_mask = '0; b_wdata = '0;

    //          a: req we addr mask wdata   b: req we addr mask wdata   ga gb rva rvb ncs rd
    tbl[0]  = mk(1,1,3,'h01,'hFF, 0,0,0,0,0,       1,0,0,0,1,'h00);
    tbl[1]  = mk(1,0,3,0,0,       0,0,0,0,0,       1,0,0,0,0,'h00);
    tbl[2]  = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,0,0,'h00);
    tbl[3]  = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,0,1,'h00);
    tbl[4]  = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,1,0,1,'hFE);
    tbl[5]  = mk(0,0,0,0,0,       1,1,5,0,'h5A,    0,1,0,0,1,'hFE);
    tbl[6]  = mk(1,0,3,0,0,       1,0,5,0,0,       1,0,0,0,0,'hFE);
    tbl[7]  = mk(1,0,3,0,0,       1,0,5,0,0,       0,1,0,0,0,'hFE);
    tbl[8]  = mk(1,0,3,0,0,       1,0,5,0,0,       1,0,0,0,0,'hFE);
    tbl[9]  = mk(1,0,3,0,0,       1,0,5,0,0,       0,1,1,0,0,'hFE);
    tbl[10] = mk(1,0,3,0,0,       1,0,5,0,0,       1,0,0,1,0,'h5A);
    tbl[11] = mk(1,0,3,0,0,       1,0,5,0,0,       0,1,1,0,0,'hFE);
    tbl[12] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,1,0,'h5A);
    tbl[13] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,1,0,1,'hFE);
    tbl[14] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,1,1,'h5A);
    tbl[15] = mk(1,1,7,'hF0,'h3C, 0,0,0,0,0,       1,0,0,0,1,'h5A);
    tbl[16] = mk(0,0,0,0,0,       1,0,7,0,0,       0,1,0,0,0,'h5A);
    tbl[17] = mk(1,0,7,0,0,       0,0,0,0,0,       1,0,0,0,0,'h5A);
    tbl[18] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,0,0,'h5A);
    tbl[19] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,0,1,1,'h0C);
    tbl[20] = mk(0,0,0,0,0,       0,0,0,0,0,       0,0,1,0,1,'h0C);

    #1 n_reset = 1'b0;
    #2;
    chk("rst init_done", 32'(init_done), 0);
    chk("rst n_cs",      32'(sram_n_cs), 1);
    chk("rst n_we",      32'(sram_n_we), 1);
    chk("rst n_oe",      32'(sram_n_oe), 1);
    chk("rst mask",      32'(sram_mask), 32'hFF);
    chk("rst ad",        32'(sram_ad), 0);
    chk("rst din",       32'(sram_din), 0);
    chk("rst rdata",     32'(rdata), 0);
    chk("rst gnt",       32'({a_gnt, b_gnt}), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    // Clear sequence with both requesters pending
    wr = 0; gnt_bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if ((a_gnt | b_gnt) && !init_done) gnt_bad = 1;
      if (!sram_n_cs) begin
        chk($sformatf("init ad w%0d", wr),   32'(sram_ad), 32'(wr));
        chk($sformatf("init we w%0d", wr),   32'({sram_n_we, sram_n_oe}), 32'b01);
        chk($sformatf("init mask w%0d", wr), 32'(sram_mask), 0);
        chk($sformatf("init din w%0d", wr),  32'(sram_din), 0);
        chk($sformatf("init done w%0d", wr), 32'(init_done), 32'(wr == DD - 1));
        wr++;
      end
      if (init_done) break;
    end
    chk("init write count", 32'(wr), 32'(DD));
    chk("init early gnt",   32'(gnt_bad), 0);
    chk("first tie a_gnt",  32'({a_gnt, b_gnt}), 32'b10);
    idle();
    next_row();
    @(negedge clk);
    chk("no wrap n_cs", 32'(sram_n_cs), 1);
    chk("init_done hold", 32'(init_done), 1);
    next_row();

    for (int i = 0; i < 21; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr;
      a_mask = tbl[i].a_mask; a_wdata = tbl[i].a_wdata;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr;
      b_mask = tbl[i].b_mask; b_wdata = tbl[i].b_wdata;
      @(negedge clk);
      chk($sformatf("row%0d a_gnt", i),    32'(a_gnt),     32'(tbl[i].e_ga));
      chk($sformatf("row%0d b_gnt", i),    32'(b_gnt),     32'(tbl[i].e_gb));
      chk($sformatf("row%0d a_rvalid", i), 32'(a_rvalid),  32'(tbl[i].e_rva));
      chk($sformatf("row%0d b_rvalid", i), 32'(b_rvalid),  32'(tbl[i].e_rvb));
      chk($sformatf("row%0d n_cs", i),     32'(sram_n_cs), 32'(tbl[i].e_ncs));
      chk($sformatf("row%0d rdata", i),    32'(rdata),     32'(tbl[i].e_rd));
      next_row();
    end

    // Pin-level view of a write, an idle cycle and a read
    idle();
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd9; a_mask = 8'h00; a_wdata = 8'h81;
    @(negedge clk); chk("pin wr a_gnt", 32'(a_gnt), 1);
    next_row();
    idle();
    @(negedge clk);
    chk("pin wr ctl",  32'({sram_n_cs, sram_n_we, sram_n_oe}), 32'b001);
    chk("pin wr ad",   32'(sram_ad), 9);
    chk("pin wr din",  32'(sram_din), 32'h81);
    chk("pin wr mask", 32'(sram_mask), 0);
    next_row();
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd9; b_mask = 8'hFF;
    @(negedge clk);
    chk("pin idle ctl",  32'({sram_n_cs, sram_n_we, sram_n_oe}), 32'b111);
    chk("pin idle mask", 32'(sram_mask), 32'hFF);
    chk("pin idle hold", 32'({sram_ad, sram_din}), 32'({5'd9, 8'h81}));
    chk("pin rd b_gnt",  32'(b_gnt), 1);
    next_row();
    idle();
    @(negedge clk);
    chk("pin rd ctl", 32'({sram_n_cs, sram_n_we, sram_n_oe}), 32'b010);
    chk("pin rd ad",  32'(sram_ad), 9);
    next_row();
    @(negedge clk);
    next_row();
    @(negedge clk);
    chk("pin rd b_rvalid", 32'(b_rvalid), 1);
    chk("pin rd rdata",    32'(rdata), 32'h81);
    next_row();

    // Clear taken with two reads in flight
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd3;
    @(negedge clk); chk("clr a_gnt", 32'(a_gnt), 1);
    next_row();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 5'd5; clr_start = 1'b1;
    @(negedge clk); chk("clr b_gnt", 32'(b_gnt), 1);
    next_row();
    clr_start = 1'b0; b_req = 1'b0; a_req = 1'b1; a_addr = 5'd3;
    idle_n = 0; gnt_bad = 0; a_rv_j = -1; b_rv_j = -1; a_rd = '0; b_rd = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (a_rvalid) begin a_rv_j = j; a_rd = rdata; end
      if (b_rvalid) begin b_rv_j = j; b_rd = rdata; end
      if (init_done) break;
      if (a_gnt | b_gnt) gnt_bad = 1;
      idle_n++;
      next_row();
    end
    chk("clr no-gnt cycles", 32'(idle_n), 32'(DD));
    chk("clr gnt during init", 32'(gnt_bad), 0);
    chk("clr a_rvalid slot", 32'(a_rv_j), 1);
    chk("clr a rdata", 32'(a_rd), 32'hFE);
    chk("clr b_rvalid slot", 32'(b_rv_j), 2);
    chk("clr b rdata", 32'(b_rd), 32'h5A);
    chk("clr regrant", 32'(a_gnt), 1);
    next_row();
    idle();
    @(negedge clk); next_row();
    @(negedge clk); next_row();
    @(negedge clk);
    chk("clr reread valid", 32'(a_rvalid), 1);
    chk("clr reread data",  32'(rdata), 0);
    next_row();

    // Reset with a read in flight
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd9;
    @(negedge clk); chk("rst rd a_gnt", 32'(a_gnt), 1);
    next_row();
    idle();
    n_reset = 1'b0;
    #1;
    chk("arst init_done", 32'(init_done), 0);
    chk("arst ctl",  32'({sram_n_cs, sram_n_we, sram_n_oe}), 32'b111);
    chk("arst mask", 32'(sram_mask), 32'hFF);
    chk("arst ad",   32'(sram_ad), 0);
    chk("arst din",  32'(sram_din), 0);
    chk("arst rdata", 32'(rdata), 0);
    rv_seen = 0;
    repeat (2) @(negedge clk) if (a_rvalid | b_rvalid) rv_seen = 1;
    n_reset = 1'b1;
    repeat (4) @(negedge clk) if (a_rvalid | b_rvalid) rv_seen = 1;
    chk("arst no rvalid", 32'(rv_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
